multdiv_scheduler: RTL and testbench
====================================

# multdiv_scheduler

Sequencing and write-back controller for the processor's multi-cycle multiply/divide unit. Accepts a mult/div issue from the X stage and fires a one-cycle start pulse into the unit. Stalls the front of the pipeline while the operation runs, enforces a timeout, and arbitrates the single regfile write port between the W stage and the multdiv result, including exception status writes to `$rstatus`.

## Interface
- `TIMEOUT`, default 64: max cycles after the start pulse to wait for `md_ready` before forcing an exception.
- `RSTATUS`, default 30: register written on a multdiv exception.
- `clock` in 1: master clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: X stage holds a mult or div.
- `issue_is_div` in 1: 1 = div, 0 = mult.
- `issue_rd` in 5: destination register of the issued op.
- `issue_ack` out 1: issue accepted this cycle.
- `stall_pipe` out 1: freeze PC and F/D.
- `md_start_mult` out 1: one-cycle start pulse to the multdiv unit.
- `md_start_div` out 1: one-cycle start pulse to the multdiv unit.
- `md_ready` in 1: multdiv unit result-ready.
- `md_exception` in 1: multdiv unit exception flag.
- `md_result` in 32: multdiv unit result.
- `w_we` in 1: W-stage write request.
- `w_rd` in 5: W-stage destination register.
- `w_data` in 32: W-stage write data.
- `ctrl_writeEnable` out 1: regfile write port.
- `ctrl_writeReg` out 5: regfile write port.
- `data_writeReg` out 32: regfile write port.

## Operation
- **States:** IDLE, BUSY, WRITE.
- **IDLE:**
  - `issue_ack = issue_valid`.
  - On ack: `md_start_mult`/`md_start_div` pulse per `issue_is_div` in the same cycle.
  - Latch rd and op type; clear the counter; go to BUSY.
- **BUSY:**
  - Counter increments each cycle.
  - On `md_ready`: latch `md_result` and `md_exception`, go to WRITE.
  - If the counter reaches `TIMEOUT` without `md_ready`: latch exception = 1, go to WRITE.
- **WRITE:**
  - If `w_we` = 1, the W stage owns the port this cycle and the scheduler waits in WRITE.
  - Otherwise the scheduler drives the port and returns to IDLE.
- **Write data:**
  - No exception: write the latched result to the latched rd.
  - Exception: write `RSTATUS` with 4 for mult or 5 for div; rd is not written.
- **Register 0:** a write to register 0 from either source drives `ctrl_writeEnable` = 0. A scheduler write with rd = 0 still completes and returns to IDLE.
- **Pass-through:** when the scheduler is not driving the port, `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg` follow `w_we`/`w_rd`/`w_data`.
- **Stall:** `stall_pipe = issue_ack | (state != IDLE)`.
- **Pipeline contract:** on `issue_ack` the pipeline loads a nop into D/X, overriding the stall hold, so `issue_valid` is low for the rest of the operation.
- **Issue outside IDLE:** `issue_valid` is ignored outside IDLE.
- **Stale ready:** `md_ready` seen in IDLE or WRITE is ignored.
- **Start pulses:** never asserted outside the ack cycle.

## Timing
- **Reset values:** state IDLE, counter 0, latched rd/result 0. `issue_ack`, `stall_pipe`, `md_start_*` = 0. Write port is in pass-through.
- **Reset mid-operation:** returns to IDLE at the next edge with no write. The multdiv unit is not reset; its late ready is ignored.
- **Nominal timeline:**
  - Accept at cycle T.
  - `md_ready` at T+k.
  - Write at T+k+1 when `w_we` = 0.
  - `stall_pipe` deasserts at T+k+2.
- Each cycle of W conflict adds one cycle to the write and to the stall.
- **Timeout:** the forced exception write occurs at T+`TIMEOUT`+1 at the earliest.
- **Counter:** 7 bits, saturating, compared against `TIMEOUT`. `TIMEOUT` must be ≤ 127.
- All outputs except the write-port mux and `issue_ack`/`md_start_*`/`stall_pipe` (combinational from state and inputs) are registered.

## Structure
- Package `multdiv_sched_pkg` holds:
  - the state encoding;
  - `EXC_MULT` = 4 and `EXC_DIV` = 5;
  - the `RSTATUS` default.
- One sub-module, `md_timeout_counter`: clear, enable, saturate, `expired` output.

## Test plan
- **Basic mult:** mult rd = 5 with A = 3, B = 7, `md_ready` at T+33 → `md_start_mult` high only at T; `stall_pipe` high T..T+34; write r5 = 21 at T+34; stall low at T+35.
- **Div exception:** div by zero, `md_ready` and `md_exception` at T+33 → write `$30` = 5 at T+34; rd untouched.
- **W-stage conflict:** `w_we` = 1, `w_rd` = 3, `w_data` = 0xAA during WRITE → r3 = 0xAA written that cycle; multdiv write one cycle later; stall extended by one cycle.
- **Timeout:** `md_ready` never asserted, `TIMEOUT` = 64, mult → write `$30` = 4 at T+65.
- **Reset in BUSY:** reset pulse at T+10 → IDLE and `stall_pipe` = 0 at T+11; a later `md_ready` produces no write.
- **rd = 0:** mult rd = 0 → no `ctrl_writeEnable` in the completion cycle; FSM returns to IDLE normally.

Source files
------------

// File: rtl/multdiv_sched_pkg.sv
// Shared types and constants for the multdiv sequencing / write-back controller.
package multdiv_sched_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 7;
  localparam int unsigned TIMEOUT_DEFAULT = 64;
  localparam int unsigned RSTATUS_DEFAULT = 30;

  localparam logic [DATA_W-1:0] EXC_MULT = 32'd4;
  localparam logic [DATA_W-1:0] EXC_DIV  = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WRITE = 2'd2
  } md_state_e;

  // One regfile write-port transaction
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating cycle counter that flags when a multdiv operation has run out of time.
module md_timeout_counter
  import multdiv_sched_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted in the cycle whose increment reaches LIMIT, i.e. LIMIT cycles after the start pulse
  assign expired_o = en_i && ((32'(count_q) + 32'd1) >= LIMIT);

endmodule

// File: rtl/multdiv_scheduler.sv
// Issues mult/div ops to the multdiv unit, stalls the front end while they run,
// and shares the single regfile write port with the W stage.
module multdiv_scheduler
  import multdiv_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned RSTATUS = RSTATUS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ack,
  output logic              stall_pipe,
  output logic              md_start_mult,
  output logic              md_start_div,
  input  logic              md_ready,
  input  logic              md_exception,
  input  logic [DATA_W-1:0] md_result,
  input  logic              w_we,
  input  logic [REG_W-1:0]  w_rd,
  input  logic [DATA_W-1:0] w_data,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  md_state_e         state_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] result_q;
  logic              exc_q;
  logic              is_div_q;

  logic   timeout_c;
  logic   sched_drive_c;
  rf_wr_t sched_wr_c;
  rf_wr_t rf_wr_c;

  assign issue_ack     = !reset && (state_q == ST_IDLE) && issue_valid;
  assign md_start_mult = issue_ack && !issue_is_div;
  assign md_start_div  = issue_ack && issue_is_div;
  assign stall_pipe    = issue_ack || (state_q != ST_IDLE);

  md_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (issue_ack),
    .en_i      (state_q == ST_BUSY),
    .expired_o (timeout_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rd_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_ack) begin
            rd_q     <= issue_rd;
            is_div_q <= issue_is_div;
            exc_q    <= 1'b0;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A ready in the expiry cycle still wins over the forced exception
          if (md_ready) begin
            result_q <= md_result;
            exc_q    <= md_exception;
            state_q  <= ST_WRITE;
          end else if (timeout_c) begin
            exc_q    <= 1'b1;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!w_we) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sched_drive_c = !reset && (state_q == ST_WRITE) && !w_we;

  // Write-port mux: W stage has priority, register 0 is never written
  always_comb begin
    sched_wr_c.we    = 1'b1;
    sched_wr_c.waddr = exc_q ? REG_W'(RSTATUS) : rd_q;
    sched_wr_c.data  = exc_q ? (is_div_q ? EXC_DIV : EXC_MULT) : result_q;

    rf_wr_c = '{we: w_we, waddr: w_rd, data: w_data};
    if (sched_drive_c) begin
      rf_wr_c = sched_wr_c;
    end
    if (rf_wr_c.waddr == '0) begin
      rf_wr_c.we = 1'b0;
    end
  end

  assign ctrl_writeEnable = rf_wr_c.we;
  assign ctrl_writeReg    = rf_wr_c.waddr;
  assign data_writeReg    = rf_wr_c.data;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Self-checking bench for multdiv_scheduler against a per-operation timeline model.
module tb_multdiv_scheduler;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned RSTATUS = 30;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_div;
  logic [4:0]  issue_rd;
  logic        issue_ack;
  logic        stall_pipe;
  logic        md_start_mult;
  logic        md_start_div;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        w_we;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks = 0;
  int errors = 0;

  multdiv_scheduler #(
    .TIMEOUT (TIMEOUT),
    .RSTATUS (RSTATUS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_is_div     (issue_is_div),
    .issue_rd         (issue_rd),
    .issue_ack        (issue_ack),
    .stall_pipe       (stall_pipe),
    .md_start_mult    (md_start_mult),
    .md_start_div     (md_start_div),
    .md_ready         (md_ready),
    .md_exception     (md_exception),
    .md_result        (md_result),
    .w_we             (w_we),
    .w_rd             (w_rd),
    .w_data           (w_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One mult/div operation. k = cycle offset of md_ready (-1 = never); conflict = W-stage
  // cycles that occupy the port once the result is due; tail adds one idle cycle afterwards.
  task automatic run_op(input string name, input logic is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic unit_exc,
                        input int k, input int conflict, input logic [4:0] cf_rd,
                        input logic [31:0] cf_data, input bit tail);
    logic [31:0] res;
    logic        exp_exc;
    logic [4:0]  ereg;
    logic [31:0] edata;
    logic [3:0]  exp_ctl;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          eff;
    int          wr_off;
    int          last;
    if (is_div) res = (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
    else        res = a * b;
    if (k >= 1 && k <= int'(TIMEOUT)) begin
      eff     = k;
      exp_exc = unit_exc;
    end else begin
      eff     = int'(TIMEOUT);
      exp_exc = 1'b1;
    end
    ereg   = exp_exc ? 5'(RSTATUS) : rd;
    edata  = exp_exc ? (is_div ? 32'd5 : 32'd4) : res;
    wr_off = eff + 1 + conflict;
    last   = tail ? wr_off + 1 : wr_off;
    for (int off = 0; off <= last; off++) begin
      @(negedge clock);
      issue_valid  = (off == 0) ? 1'b1 : ((off <= wr_off) ? 1'($urandom_range(0, 1)) : 1'b0);
      issue_is_div = (off == 0) ? is_div : 1'($urandom_range(0, 1));
      issue_rd     = (off == 0) ? rd : 5'($urandom);
      md_ready     = (off == k);
      md_exception = md_ready ? unit_exc : 1'($urandom_range(0, 1));
      md_result    = md_ready ? res : $urandom;
      if (off > eff && off < wr_off) begin
        w_we = 1'b1; w_rd = cf_rd; w_data = cf_data;
      end else begin
        w_we = (off == wr_off) ? 1'b0 : 1'($urandom_range(0, 1));
        w_rd = 5'($urandom); w_data = $urandom;
      end
      #2;
      exp_ctl = {off == 0, off <= wr_off, off == 0 && !is_div, off == 0 && is_div};
      if (off == wr_off) begin
        exp_we = (ereg != 5'd0); exp_reg = ereg; exp_data = edata;
      end else begin
        exp_we = w_we && (w_rd != 5'd0); exp_reg = w_rd; exp_data = w_data;
      end
      checks++;
      if ({issue_ack, stall_pipe, md_start_mult, md_start_div} !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl off=%0d ack/stall/smul/sdiv got=%b exp=%b", name, off,
                 {issue_ack, stall_pipe, md_start_mult, md_start_div}, exp_ctl);
      end
      checks++;
      if (ctrl_writeEnable !== exp_we) begin
        errors++;
        $display("FAIL %s we off=%0d got=%b exp=%b", name, off, ctrl_writeEnable, exp_we);
      end
      if (exp_we) begin
        checks++;
        if ({ctrl_writeReg, data_writeReg} !== {exp_reg, exp_data}) begin
          errors++;
          $display("FAIL %s port off=%0d got=r%0d:%h exp=r%0d:%h", name, off,
                   ctrl_writeReg, data_writeReg, exp_reg, exp_data);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      reset        = (c < 3);
      issue_valid  = (c < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue_is_div = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom);
      md_ready     = 1'($urandom_range(0, 1));
      md_exception = 1'($urandom_range(0, 1));
      md_result    = $urandom;
      w_we         = 1'($urandom_range(0, 1));
      w_rd         = 5'($urandom);
      w_data       = $urandom;
      #2;
      checks++;
      if ({issue_ack, stall_pipe, md_start_mult, md_start_div} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctl c=%0d got=%b exp=0000", c,
                 {issue_ack, stall_pipe, md_start_mult, md_start_div});
      end
      checks++;
      if (ctrl_writeEnable !== (w_we && w_rd != 5'd0)) begin
        errors++;
        $display("FAIL reset_passthru_we c=%0d got=%b exp=%b", c, ctrl_writeEnable,
                 w_we && w_rd != 5'd0);
      end
      if (w_we && w_rd != 5'd0) begin
        checks++;
        if ({ctrl_writeReg, data_writeReg} !== {w_rd, w_data}) begin
          errors++;
          $display("FAIL reset_passthru c=%0d got=r%0d:%h exp=r%0d:%h", c,
                   ctrl_writeReg, data_writeReg, w_rd, w_data);
        end
      end
    end
  endtask

  task automatic test_basic_mult();
    run_op("basic_mult", 1'b0, 5'd5, 32'd3, 32'd7, 1'b0, 33, 0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_div_exception();
    run_op("div_exc", 1'b1, 5'd12, 32'd100, 32'd0, 1'b1, 33, 0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_w_conflict();
    run_op("w_conflict", 1'b0, 5'd7, 32'd6, 32'd9, 1'b0, 12, 1, 5'd3, 32'h0000_00AA, 1'b1);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1'b0, 5'd8, 32'd2, 32'd2, 1'b0, -1, 0, 5'd0, 32'd0, 1'b1);
    run_op("ready_at_limit", 1'b1, 5'd9, 32'd50, 32'd7, 1'b0, 64, 0, 5'd0, 32'd0, 1'b1);
    run_op("ready_late", 1'b1, 5'd10, 32'd50, 32'd7, 1'b0, 65, 0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_rd_zero();
    run_op("rd_zero", 1'b0, 5'd0, 32'd4, 32'd5, 1'b0, 5, 0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reset_busy();
    for (int off = 0; off <= 30; off++) begin
      @(negedge clock);
      reset        = (off == 10);
      issue_valid  = (off == 0);
      issue_is_div = 1'b0;
      issue_rd     = 5'd9;
      md_ready     = (off == 20);
      md_exception = 1'b0;
      md_result    = $urandom;
      w_we         = 1'($urandom_range(0, 1));
      w_rd         = 5'($urandom);
      w_data       = $urandom;
      #2;
      if (off < 10) begin
        checks++;
        if ({issue_ack, stall_pipe, md_start_mult, md_start_div} !== {off == 0, 1'b1, off == 0, 1'b0}) begin
          errors++;
          $display("FAIL reset_busy_pre off=%0d got=%b", off,
                   {issue_ack, stall_pipe, md_start_mult, md_start_div});
        end
      end else if (off > 10) begin
        checks++;
        if ({issue_ack, stall_pipe, md_start_mult, md_start_div} !== 4'b0000) begin
          errors++;
          $display("FAIL reset_busy_post off=%0d got=%b exp=0000", off,
                   {issue_ack, stall_pipe, md_start_mult, md_start_div});
        end
        checks++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !==
            {w_we && w_rd != 5'd0, w_rd, w_data}) begin
          errors++;
          $display("FAIL reset_busy_port off=%0d got=%b r%0d:%h exp=%b r%0d:%h", off,
                   ctrl_writeEnable, ctrl_writeReg, data_writeReg, w_we && w_rd != 5'd0, w_rd, w_data);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        is_div;
    logic [31:0] b;
    for (int n = 0; n < 24; n++) begin
      is_div = 1'($urandom_range(0, 1));
      b      = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      run_op("random", is_div, 5'($urandom), $urandom, b,
             is_div ? (b == 32'd0) : ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 70)),
             int'($urandom_range(0, 3)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = 5'd0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    w_we = 1'b0; w_rd = 5'd0; w_data = 32'd0;
    test_reset();
    test_basic_mult();
    test_div_exception();
    test_w_conflict();
    test_timeout();
    test_rd_zero();
    test_reset_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
